// File: rtl/fp_normalize_round.sv
// fp_normalize_round
//   Last stage of the FP add/sub datapath. It takes the aligned,
//   carry-adjusted mantissa from the operation stage and:
//     1. normalizes it by the leading-zero count, limited so that the
//        exponent never drops below 1 (subnormal results keep exponent
//        field 0);
//     2. rounds to nearest, ties to even;
//     3. packs the IEEE-754 word and saturates to infinity on overflow.
//   Sequence: IDLE -> NORMALIZE -> ROUND -> DONE. The first DONE cycle packs
//   the result. out_valid rises three edges after the accept edge.
//
// Optional feature macro: FP_ADD_FLAGS_EN
//   When defined, the flags port {overflow, underflow, inexact} and its logic
//   are present. When undefined, neither exists. Result behaviour is the
//   same in both builds.
//
// Ports
//   clk            : clock, rising edge
//   reset          : synchronous, active-high
//   in_valid       : upstream data valid
//   in_ready       : high only in IDLE (combinational from state)
//   mant_in        : {hidden, fraction, G, R, S}
//   leading_zeros  : leading-zero count of mant_in
//   exp_in         : exponent of the larger-magnitude operand
//   carry          : carry out of the mantissa adder
//   real_operation : 1 = effective subtraction
//   real_sign      : sign of the result
//   out_valid      : result valid (registered)
//   out_ready      : downstream accepts
//   result         : packed {sign, exponent, fraction} (registered)
//   flags          : {overflow, underflow, inexact} (FP_ADD_FLAGS_EN only)

module fp_normalize_round #(
   parameter  int Size     = 32,
   localparam int ExpSize  = (Size == 64) ? 11 : 8,
   localparam int MantSize = (Size == 64) ? 52 : 23,
   localparam int MantW    = MantSize + 4,
   localparam int LzW      = $clog2(MantSize + 4)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MantW-1:0]   mant_in,
   input  logic [LzW-1:0]     leading_zeros,
   input  logic [ExpSize-1:0] exp_in,
   input  logic               carry,
   input  logic               real_operation,
   input  logic               real_sign,
   output logic               out_valid,
   input  logic               out_ready,
`ifdef FP_ADD_FLAGS_EN
   output logic [2:0]         flags,
`endif
   output logic [Size-1:0]    result
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_NORMALIZE = 2'd1;
   localparam logic [1:0] ST_ROUND     = 2'd2;
   localparam logic [1:0] ST_DONE      = 2'd3;

   localparam logic [ExpSize:0] EXP_ONE = {{ExpSize{1'b0}}, 1'b1};
   // The all-ones biased exponent. It is the first value that cannot be finite.
   localparam logic [ExpSize:0] EXP_MAX = {1'b0, {ExpSize{1'b1}}};

   logic [1:0]         r_state;
   logic [MantW-1:0]   r_mant;
   logic [LzW-1:0]     r_lz;
   logic [ExpSize:0]   r_exp;       // one extra bit so carries never wrap
   logic               r_sign;
   logic               r_zero;
   logic               r_subnormal;
   logic               r_out_valid;
   logic [Size-1:0]    r_result;

   // ---------------------------------------------------------------
   // Normalization shift: min(lz, exp-1), or 0 when exp is 0
   // ---------------------------------------------------------------
   logic [ExpSize:0]   w_lz_ext;
   logic [ExpSize:0]   w_exp_m1;
   logic [ExpSize:0]   w_shift;
   logic [MantW-1:0]   w_mant_shifted;

   assign w_lz_ext = {{(ExpSize + 1 - LzW){1'b0}}, r_lz};
   assign w_exp_m1 = r_exp - EXP_ONE;

   always_comb begin
      w_shift = '0;
      if (r_exp != '0) begin
         w_shift = (w_lz_ext > w_exp_m1) ? w_exp_m1 : w_lz_ext;
      end
   end

   assign w_mant_shifted = r_mant << w_shift;

   // ---------------------------------------------------------------
   // Round to nearest even on {hidden, fraction}
   // ---------------------------------------------------------------
   logic                w_lsb;
   logic                w_guard;
   logic                w_sticky;
   logic                w_inc;
   logic [MantSize+1:0] w_rounded;   // [MantSize+1] = carry out of hidden

   assign w_lsb     = r_mant[3];
   assign w_guard   = r_mant[2];
   assign w_sticky  = r_mant[1] | r_mant[0];
   assign w_inc     = w_guard & (w_lsb | w_sticky);
   assign w_rounded = {1'b0, r_mant[MantW-1:3]} + {{(MantSize + 1){1'b0}}, w_inc};

`ifdef FP_ADD_FLAGS_EN
   logic       r_inexact;
   logic [2:0] r_flags;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_mant      <= '0;
         r_lz        <= '0;
         r_exp       <= '0;
         r_sign      <= 1'b0;
         r_zero      <= 1'b0;
         r_subnormal <= 1'b0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
`ifdef FP_ADD_FLAGS_EN
         r_inexact   <= 1'b0;
         r_flags     <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_mant  <= mant_in;
                  r_lz    <= leading_zeros;
                  // A carry only moves the exponent on an effective addition.
                  r_exp   <= {1'b0, exp_in}
                             + {{ExpSize{1'b0}}, carry & ~real_operation};
                  r_sign  <= real_sign;
                  r_state <= ST_NORMALIZE;
               end
            end

            ST_NORMALIZE: begin
               r_zero      <= (r_mant == '0);
               r_mant      <= w_mant_shifted;
               r_exp       <= r_exp - w_shift;
               r_subnormal <= ~w_mant_shifted[MantW-1];
               r_state     <= ST_ROUND;
            end

            ST_ROUND: begin
`ifdef FP_ADD_FLAGS_EN
               r_inexact <= w_guard | w_sticky;
`endif
               r_mant[2:0] <= 3'b000;
               if (w_rounded[MantSize+1]) begin
                  // 1.11..1 rounded up: the mantissa becomes 1.00..0 one binade higher.
                  r_mant[MantW-1:3] <= {1'b1, {MantSize{1'b0}}};
                  r_exp             <= r_exp + EXP_ONE;
               end else begin
                  r_mant[MantW-1:3] <= w_rounded[MantSize:0];
                  // A subnormal that rounds into the hidden bit becomes the
                  // smallest normal number. Otherwise its exponent field is 0.
                  if (r_subnormal) begin
                     r_exp <= w_rounded[MantSize] ? EXP_ONE : '0;
                  end
               end
               r_state <= ST_DONE;
            end

            ST_DONE: begin
               if (!r_out_valid) begin
                  // First DONE cycle: pack the result. It then holds until it is taken.
                  r_out_valid <= 1'b1;
                  if (r_zero) begin
                     r_result <= '0;
                  end else if (r_exp >= EXP_MAX) begin
                     r_result <= {r_sign, {ExpSize{1'b1}}, {MantSize{1'b0}}};
                  end else begin
                     r_result <= {r_sign, r_exp[ExpSize-1:0], r_mant[MantW-2:3]};
                  end
`ifdef FP_ADD_FLAGS_EN
                  r_flags <= {~r_zero & (r_exp >= EXP_MAX),
                              ~r_zero & r_subnormal & r_inexact,
                              r_inexact};
`endif
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = r_out_valid;
   assign result    = r_result;
`ifdef FP_ADD_FLAGS_EN
   assign flags     = r_flags;
`endif

endmodule

// File: tb/tb_fp_normalize_round.sv
module tb_fp_normalize_round;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [26:0] mant_in;
   logic [4:0]  leading_zeros;
   logic [7:0]  exp_in;
   logic        carry;
   logic        real_operation;
   logic        real_sign;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
`ifdef FP_ADD_FLAGS_EN
   logic [2:0]  flags;
`endif

   int checks = 0;
   int errors = 0;

   fp_normalize_round #(.Size(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .mant_in        (mant_in),
      .leading_zeros  (leading_zeros),
      .exp_in         (exp_in),
      .carry          (carry),
      .real_operation (real_operation),
      .real_sign      (real_sign),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
`ifdef FP_ADD_FLAGS_EN
      .flags          (flags),
`endif
      .result         (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [26:0] mant;
      logic [4:0]  lz;
      logic [7:0]  exp;
      logic        carry;
      logic        op;
      logic        sign;
      logic [31:0] exp_result;
      logic [2:0]  exp_flags;   // {overflow, underflow, inexact}
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual %h expected %h", name, act, expv);
      end
   endtask

   task automatic drive(input vec_t v);
      mant_in        = v.mant;
      leading_zeros  = v.lz;
      exp_in         = v.exp;
      carry          = v.carry;
      real_operation = v.op;
      real_sign      = v.sign;
   endtask

   // Present v, wait for the accept edge, then wait for out_valid. Returns the edge count.
   task automatic accept_and_wait(input vec_t v, output int cyc);
      @(negedge clk);
      drive(v);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 1) check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      end
   endtask

   initial begin
      int cyc;
      vec_t v;
      //        mant          lz     exp     c     op    s     result          flags
      vecs[0]  = '{27'h4000000, 5'd0,  8'd127, 1'b1, 1'b0, 1'b0, 32'h40000000, 3'b000};
      vecs[1]  = '{27'h2000000, 5'd1,  8'd127, 1'b0, 1'b1, 1'b0, 32'h3F000000, 3'b000};
      vecs[2]  = '{27'h4000004, 5'd0,  8'd127, 1'b0, 1'b0, 1'b0, 32'h3F800000, 3'b001};
      vecs[3]  = '{27'h400000C, 5'd0,  8'd127, 1'b0, 1'b0, 1'b0, 32'h3F800002, 3'b001};
      vecs[4]  = '{27'h7FFFFFC, 5'd0,  8'd127, 1'b0, 1'b0, 1'b0, 32'h40000000, 3'b001};
      vecs[5]  = '{27'h4000000, 5'd0,  8'd254, 1'b1, 1'b0, 1'b0, 32'h7F800000, 3'b100};
      vecs[6]  = '{27'h0000000, 5'd27, 8'd127, 1'b0, 1'b1, 1'b1, 32'h00000000, 3'b000};
      vecs[7]  = '{27'h2000000, 5'd1,  8'd1,   1'b0, 1'b1, 1'b0, 32'h00400000, 3'b000};
      vecs[8]  = '{27'h2000004, 5'd1,  8'd1,   1'b0, 1'b1, 1'b0, 32'h00400000, 3'b011};
      vecs[9]  = '{27'h3FFFFFC, 5'd1,  8'd1,   1'b0, 1'b1, 1'b0, 32'h00800000, 3'b011};
      vecs[10] = '{27'h4000000, 5'd0,  8'd127, 1'b0, 1'b0, 1'b1, 32'hBF800000, 3'b000};
      vecs[11] = '{27'h7FFFFFC, 5'd0,  8'd254, 1'b0, 1'b0, 1'b0, 32'h7F800000, 3'b101};
      vecs[12] = '{27'h0200000, 5'd5,  8'd3,   1'b0, 1'b1, 1'b0, 32'h00100000, 3'b000};
      vecs[13] = '{27'h4000000, 5'd0,  8'd100, 1'b1, 1'b1, 1'b0, 32'h32000000, 3'b000};
      vecs[14] = '{27'h4000006, 5'd0,  8'd127, 1'b0, 1'b0, 1'b0, 32'h3F800001, 3'b001};
      vecs[15] = '{27'h0000008, 5'd23, 8'd127, 1'b0, 1'b1, 1'b0, 32'h34000000, 3'b000};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      drive(vecs[0]);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef FP_ADD_FLAGS_EN
      check("reset_flags", {29'd0, flags}, 32'd0);
`endif

      // Table-driven vectors
      for (int i = 0; i < 16; i++) begin
         accept_and_wait(vecs[i], cyc);
         check($sformatf("latency[%0d]", i), cyc, 32'd3);
         check($sformatf("result[%0d]", i), result, vecs[i].exp_result);
`ifdef FP_ADD_FLAGS_EN
         check($sformatf("flags[%0d]", i), {29'd0, flags}, {29'd0, vecs[i].exp_flags});
`endif
         $display("vec %0d mant=%h exp=%0d -> result=%h cycles=%0d", i, vecs[i].mant, vecs[i].exp, result, cyc);
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
         check($sformatf("released[%0d]", i), {30'd0, out_valid, in_ready}, 32'd1);
      end

      // Back-pressure: out_ready low for 5 cycles in DONE, new inputs ignored
      accept_and_wait(vecs[3], cyc);
      check("bp_latency", cyc, 32'd3);
      v = vecs[5];
      @(negedge clk);
      drive(v);
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp_result[%0d]", k), result, 32'h3F800002);
         check($sformatf("bp_valid_ready[%0d]", k), {30'd0, out_valid, in_ready}, 32'd2);
`ifdef FP_ADD_FLAGS_EN
         check($sformatf("bp_flags[%0d]", k), {29'd0, flags}, 32'd1);
`endif
      end
      in_valid = 1'b0;
      $display("backpressure hold result=%h", result);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);

      // Reset while in ROUND: no result may appear
      @(negedge clk);
      drive(vecs[0]);
      in_valid = 1'b1;
      @(posedge clk);            // accept -> NORMALIZE
      #1 in_valid = 1'b0;
      @(posedge clk);            // -> ROUND
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("rst_round_in_ready", {31'd0, in_ready}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rst_round_out_valid[%0d]", k), {31'd0, out_valid}, 32'd0);
         @(posedge clk);
         #1;
      end
      check("rst_round_result", result, 32'd0);
      $display("reset during ROUND out_valid=%0d in_ready=%0d", out_valid, in_ready);

      // Recovery after reset
      accept_and_wait(vecs[1], cyc);
      check("recover_latency", cyc, 32'd3);
      check("recover_result", result, 32'h3F000000);
      $display("recovery result=%h", result);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
